// File: rtl/posit_unit_top.sv
// posit_unit_top: posit<N,ES> ADD/SUB/MUL/FMADD unit with one registered cycle of latency.
// Every operation is mapped onto one exact fixed-point A*B+C followed by a single rounding step.
module posit_unit_top #(
   parameter int unsigned WORD = 32,
   parameter int unsigned N    = 16,
   parameter int unsigned ES   = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   input  logic [WORD-1:0] operand1_i,
   input  logic [WORD-1:0] operand2_i,
   input  logic [WORD-1:0] operand3_i,
   input  logic [2:0]      op_i,
   output logic [WORD-1:0] result_o,
   output logic            out_valid_o
);
   localparam int unsigned FX_M = 2*(N-2)*(2**ES);
   localparam int unsigned FX_B = 2*FX_M+2;
   localparam int unsigned FW   = N-1-ES;
   localparam int unsigned SW   = $clog2(FX_B)+2;
   localparam int unsigned CW   = N+ES+FX_B-2;
   localparam logic signed [SW-1:0] MAXSC = SW'((N-2)*(2**ES));

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_MUL   = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_FMADD = 3'd4;

   localparam logic [N-1:0] P_ONE    = {2'b01, {(N-2){1'b0}}};
   localparam logic [N-1:0] P_NAR    = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] P_MAXPOS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] P_MINPOS = {{(N-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic                 nar;
      logic                 sgn;
      logic signed [SW-1:0] scale;
      logic [FW:0]          sig;
   } dec_t;

   function automatic dec_t decode(input logic [N-1:0] p);
      dec_t                 d;
      logic [N-2:0]         body;
      logic [N-2:0]         rest;
      logic signed [SW-1:0] run_s;
      logic signed [SW-1:0] k;
      int unsigned          run;
      logic                 done;
      body = p[N-1] ? (~p[N-2:0] + 1'b1) : p[N-2:0];
      run  = 0;
      done = 1'b0;
      for (int unsigned i = 0; i < N-1; i++) begin
         if (!done && body[N-2-i] == body[N-2]) run++;
         else done = 1'b1;
      end
      run_s   = SW'(run);
      k       = body[N-2] ? run_s - SW'(1) : -run_s;
      rest    = body << (run + 1);
      d.nar   = (p == P_NAR);
      d.sgn   = p[N-1];
      d.scale = (k <<< ES) + SW'(rest[N-2 -: ES]);
      d.sig   = (p == '0) ? '0 : {1'b1, rest[FW-1:0]};
      return d;
   endfunction

   logic [N-1:0]          b_eff, c_eff;
   dec_t                  da, db, dc;
   logic [2*FW+1:0]       p_sig;
   logic [SW-1:0]         p_sh, c_sh;
   logic [FX_B+2*FW-1:0]  p_wide;
   logic [FX_B-1:0]       p_mag, c_mag, p_fx, c_fx;
   logic signed [FX_B-1:0] fixed_o;
   logic                  neg;
   logic [FX_B-2:0]       mag, frac_al;
   int unsigned           lz;
   logic signed [SW-1:0]  s, k, rlen;
   logic [N-1:0]          regv;
   logic [CW-1:0]         cat;
   logic [N-2:0]          body;
   logic                  guard, sticky, rbit, nar_any;
   logic [N-1:0]          rnd, res_mag, res_d, result_q;
   logic                  valid_q;
   logic                  unused_bits;

   // ADD/SUB become A*1 + (+/-B); MUL uses a zero addend.
   always_comb begin
      b_eff = operand2_i[N-1:0];
      c_eff = '0;
      case (op_i)
         OP_ADD:   begin b_eff = P_ONE; c_eff = operand2_i[N-1:0]; end
         OP_SUB:   begin b_eff = P_ONE; c_eff = ~operand2_i[N-1:0] + 1'b1; end
         OP_FMADD: c_eff = operand3_i[N-1:0];
         default:  ;
      endcase
   end

   assign da = decode(operand1_i[N-1:0]);
   assign db = decode(b_eff);
   assign dc = decode(c_eff);

   assign p_sig   = da.sig * db.sig;
   assign p_sh    = da.scale + db.scale + SW'(FX_M);
   assign p_wide  = {{(FX_B-2){1'b0}}, p_sig} << p_sh;
   assign p_mag   = p_wide[FX_B+2*FW-1 -: FX_B];
   assign c_sh    = dc.scale + SW'(FX_M-FW);
   assign c_mag   = {{(FX_B-FW-1){1'b0}}, dc.sig} << c_sh;
   assign p_fx    = (da.sgn ^ db.sgn) ? -p_mag : p_mag;
   assign c_fx    = dc.sgn ? -c_mag : c_mag;
   assign fixed_o = p_fx + c_fx;

   assign nar_any = da.nar | db.nar | dc.nar | (op_i == OP_DIV) | (op_i > OP_FMADD);

   // Rebuild the unbounded posit string (regime, exponent, fraction), then round on N-1 body bits.
   always_comb begin
      neg = fixed_o[FX_B-1];
      mag = neg ? (~fixed_o[FX_B-2:0] + 1'b1) : fixed_o[FX_B-2:0];
      lz  = 0;
      for (int unsigned i = 0; i < FX_B-1; i++) begin
         if (mag[i]) lz = i;
      end
      s       = SW'(lz) - SW'(FX_M);
      k       = s >>> ES;
      rlen    = (k >= 0) ? k + SW'(2) : SW'(1) - k;
      regv    = (k >= 0) ? ((~({N{1'b1}} << (k + SW'(1)))) << 1) : P_MINPOS;
      frac_al = mag << (FX_B-2-lz);
      cat     = {regv, s[ES-1:0], frac_al[FX_B-3:0]} << (SW'(N) - rlen);
      body    = cat[CW-1 -: N-1];
      guard   = cat[CW-N];
      sticky  = |cat[CW-N-1:0];
      rbit    = guard & (body[0] | sticky);
      rnd     = {1'b0, body} + {{(N-1){1'b0}}, rbit};
      if (mag == '0)          res_mag = '0;
      else if (s > MAXSC)     res_mag = P_MAXPOS;
      else if (s < -MAXSC)    res_mag = P_MINPOS;
      else if (rnd[N-1])      res_mag = P_MAXPOS;
      else                    res_mag = rnd;
      if (nar_any)            res_d = P_NAR;
      else if (neg)           res_d = -res_mag;
      else                    res_d = res_mag;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= in_valid_i;
         if (in_valid_i) result_q <= res_d;
      end
   end

   assign result_o    = {{(WORD-N){1'b0}}, result_q};
   assign out_valid_o = valid_q;

   assign unused_bits = ^{operand1_i[WORD-1:N], operand2_i[WORD-1:N], operand3_i[WORD-1:N],
                          p_wide[2*FW-1:0], frac_al[FX_B-2]};
endmodule

// File: tb/tb_posit_unit_top.sv
// Self-checking bench for posit_unit_top (posit<16,1>): directed table, corner sequences and random ops.
module tb_posit_unit_top;
   localparam int ES = 1;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3, OP_FMADD = 3'd4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic [31:0] operand1_i, operand2_i, operand3_i;
   logic [2:0]  op_i;
   logic [31:0] result_o;
   logic        out_valid_o;

   int errors = 0;
   int checks = 0;

   posit_unit_top #(.WORD(32), .N(16), .ES(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i),
      .operand1_i(operand1_i), .operand2_i(operand2_i), .operand3_i(operand3_i),
      .op_i(op_i), .result_o(result_o), .out_valid_o(out_valid_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Real value of an nb-bit posit pattern, straight from the sign/regime/exponent/fraction rules.
   function automatic real pval(input logic [31:0] bits, input int nb);
      logic [31:0] v, mask;
      int i, run, k, e;
      bit first;
      real f, w;
      mask = (32'd1 << nb) - 32'd1;
      v = bits & mask;
      if (v == 32'd0) return 0.0;
      if (v[nb-1]) v = (~v + 32'd1) & mask;
      i = nb - 2;
      first = v[i];
      run = 0;
      while (i >= 0 && v[i] == first) begin run++; i--; end
      k = first ? run - 1 : -run;
      i--;
      e = 0;
      for (int j = 0; j < ES; j++) begin
         e = e * 2;
         if (i >= 0) begin e += int'(v[i]); i--; end
      end
      f = 1.0; w = 0.5;
      while (i >= 0) begin
         if (v[i]) f += w;
         w = w / 2.0;
         i--;
      end
      f = f * (2.0 ** real'(k * (2 ** ES) + e));
      return bits[nb-1] ? -f : f;
   endfunction

   function automatic real pv(input logic [15:0] p);
      return pval(32'(p), 16);
   endfunction

   // Nearest posit by bit pattern: the tie point between p and p+1 is the 17-bit posit {p,1}.
   function automatic logic [15:0] round_posit(input real x);
      real ax, m;
      int lo, hi, mid;
      logic [15:0] p;
      if (x == 0.0) return 16'h0000;
      ax = (x < 0.0) ? -x : x;
      if (ax >= pv(16'h7FFF)) p = 16'h7FFF;
      else if (ax <= pv(16'h0001)) p = 16'h0001;
      else begin
         lo = 1; hi = 32767;
         while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (pv(16'(mid)) <= ax) lo = mid; else hi = mid;
         end
         m = pval(32'(lo * 2 + 1), 17);
         if (ax < m) p = 16'(lo);
         else if (ax > m) p = 16'(hi);
         else p = (lo % 2 == 0) ? 16'(lo) : 16'(hi);
      end
      return (x < 0.0) ? -p : p;
   endfunction

   function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a, b, c);
      if (op == OP_DIV || op > OP_FMADD) return 16'h8000;
      if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
      if (op == OP_FMADD && c == 16'h8000) return 16'h8000;
      case (op)
         OP_ADD:  return round_posit(pv(a) + pv(b));
         OP_SUB:  return round_posit(pv(a) - pv(b));
         OP_MUL:  return round_posit(pv(a) * pv(b));
         default: return round_posit(pv(a) * pv(b) + pv(c));
      endcase
   endfunction

   // Operands with scale in [-2,1]: sums and fused results stay exact in a double.
   function automatic logic [15:0] rnd_mid();
      logic [15:0] p;
      p = 16'($urandom_range(16'h2000, 16'h5FFF));
      if ($urandom_range(0, 1) == 1) p = -p;
      return p;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic apply(input logic [2:0] op, input logic [15:0] a, b, c);
      op_i       = op;
      operand1_i = {16'($urandom), a};
      operand2_i = {16'($urandom), b};
      operand3_i = {16'($urandom), c};
   endtask

   task automatic run_one(input string name, input logic [2:0] op,
                          input logic [15:0] a, b, c, req);
      @(negedge clk_i);
      apply(op, a, b, c);
      in_valid_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      check(name, result_o, {16'h0000, req});
      check({name, "_valid"}, {31'b0, out_valid_o}, 32'd1);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [15:0] a, b, c, req;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] q_exp[$];
   logic [15:0] ra, rb, rc, rexp;
   logic [2:0]  rop;

   initial begin
      vecs.push_back('{"add_1p1",     OP_ADD,   16'h4000, 16'h4000, 16'h0000, 16'h5000});
      vecs.push_back('{"sub_1m1",     OP_SUB,   16'h4000, 16'h4000, 16'h0000, 16'h0000});
      vecs.push_back('{"add_1pm1",    OP_ADD,   16'h4000, 16'hC000, 16'h0000, 16'h0000});
      vecs.push_back('{"mul_2x2",     OP_MUL,   16'h5000, 16'h5000, 16'h0000, 16'h6000});
      vecs.push_back('{"mul_1p5sq",   OP_MUL,   16'h4800, 16'h4800, 16'h0000, 16'h5200});
      vecs.push_back('{"mul_half2",   OP_MUL,   16'h3000, 16'h5000, 16'h0000, 16'h4000});
      vecs.push_back('{"fma_2h1",     OP_FMADD, 16'h5000, 16'h3000, 16'h4000, 16'h5000});
      vecs.push_back('{"fma_cancel",  OP_FMADD, 16'h4000, 16'hC000, 16'h4000, 16'h0000});
      vecs.push_back('{"fma_c0",      OP_FMADD, 16'h4800, 16'h4800, 16'h0000, 16'h5200});
      vecs.push_back('{"add_nar",     OP_ADD,   16'h8000, 16'h4000, 16'h0000, 16'h8000});
      vecs.push_back('{"mul_maxsat",  OP_MUL,   16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF});
      vecs.push_back('{"mul_minsat",  OP_MUL,   16'h0001, 16'h0001, 16'h0000, 16'h0001});
      vecs.push_back('{"mul_negmin",  OP_MUL,   16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF});
      vecs.push_back('{"div_any",     OP_DIV,   16'h4000, 16'h5000, 16'h0000, 16'h8000});
      vecs.push_back('{"reserved_op", 3'd6,     16'h4000, 16'h4000, 16'h0000, 16'h8000});
      vecs.push_back('{"sub_nar",     OP_SUB,   16'h4000, 16'h8000, 16'h0000, 16'h8000});

      rst_i = 1'b1; in_valid_i = 1'b0;
      apply(OP_ADD, 16'h0, 16'h0, 16'h0);
      repeat (2) @(negedge clk_i);
      check("reset_result", result_o, 32'h0);
      check("reset_valid", {31'b0, out_valid_o}, 32'd0);
      rst_i = 1'b0;

      foreach (vecs[i]) run_one(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].req);

      @(negedge clk_i);
      check("hold_result", result_o, 32'h0000_8000);
      check("idle_valid", {31'b0, out_valid_o}, 32'd0);

      // Asynchronous reset while a valid result is on the outputs.
      @(negedge clk_i);
      apply(OP_ADD, 16'h4000, 16'h4000, 16'h0);
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #2;
      check("pre_reset_result", result_o, 32'h0000_5000);
      check("pre_reset_valid", {31'b0, out_valid_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      check("async_reset_result", result_o, 32'h0);
      check("async_reset_valid", {31'b0, out_valid_o}, 32'd0);
      @(negedge clk_i);
      check("held_reset_result", result_o, 32'h0);
      check("held_reset_valid", {31'b0, out_valid_o}, 32'd0);
      rst_i = 1'b0;
      in_valid_i = 1'b0;
      @(negedge clk_i);
      check("post_reset_idle_valid", {31'b0, out_valid_o}, 32'd0);
      apply(OP_ADD, 16'h4000, 16'h4000, 16'h0);
      in_valid_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      check("issue_t1_valid", {31'b0, out_valid_o}, 32'd1);
      check("issue_t1_result", result_o, 32'h0000_5000);
      @(negedge clk_i);
      check("issue_t2_valid", {31'b0, out_valid_o}, 32'd0);

      // Ten back-to-back FMADDs with a zero addend.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (i > 0) begin
            check($sformatf("b2b_%0d", i - 1), result_o, {16'h0000, q_exp.pop_front()});
            check($sformatf("b2b_%0d_valid", i - 1), {31'b0, out_valid_o}, 32'd1);
         end
         ra = 16'($urandom);
         rb = 16'($urandom);
         apply(OP_FMADD, ra, rb, 16'h0000);
         q_exp.push_back(ref_op(OP_FMADD, ra, rb, 16'h0000));
         in_valid_i = 1'b1;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      check("b2b_9", result_o, {16'h0000, q_exp.pop_front()});
      check("b2b_9_valid", {31'b0, out_valid_o}, 32'd1);
      @(negedge clk_i);
      check("b2b_end_valid", {31'b0, out_valid_o}, 32'd0);

      // Random single ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rexp = ref_op(OP_MUL, ra, rb, 16'h0);
         run_one($sformatf("rnd_mul_%0d", i), OP_MUL, ra, rb, 16'h0, rexp);
      end
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 4));
         if (rop == OP_DIV) rop = OP_FMADD;
         ra = rnd_mid();
         rb = rnd_mid();
         rc = rnd_mid();
         rexp = ref_op(rop, ra, rb, rc);
         run_one($sformatf("rnd_op%0d_%0d", rop, i), rop, ra, rb, rc, rexp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
